deal_ctrl: RTL and testbench

Turn sequencer for the two-player card game. Owns the `whose` select and a `deal` strobe for the card demux. Samples the 5-bit random card on every deal and accumulates each player's score. Runs the game from the initial deal through the hit/stand turns to a registered winner.

---
 rtl/card_pkg.sv | 11 +
 rtl/deal_ctrl_if.sv | 11 +
 rtl/score_acc.sv | 38 +++
 rtl/deal_ctrl.sv | 77 +++++++
 tb/tb_deal_ctrl.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/card_pkg.sv
// card_pkg: shared FSM encoding, winner codes and card bounds for deal_ctrl
package card_pkg;
    typedef enum logic [2:0] {IDLE, INIT, P1_WAIT, P1_DRAW, P2_WAIT, P2_DRAW, RESULT} state_t;
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1 = 2'b01;
    localparam logic [1:0] WIN_P2 = 2'b10;
    localparam logic [1:0] WIN_TIE = 2'b11;
    localparam int BUST_LIMIT = 21;
    localparam int CARD_MIN = 1;
    localparam int CARD_MAX = 10;
endpackage

// File: rtl/deal_ctrl_if.sv
// deal_ctrl_if: player controls, card input and game status of the turn sequencer
interface deal_ctrl_if #(parameter int CARD_W = 5, parameter int SUM_W = 6);
    logic start, hit, stand;
    logic [CARD_W-1:0] rnd;
    logic whose, deal;
    logic [SUM_W-1:0] sum1, sum2;
    logic [1:0] winner;
    logic done, busy;
    modport master(output start, hit, stand, rnd, input whose, deal, sum1, sum2, winner, done, busy);
    modport slave(input start, hit, stand, rnd, output whose, deal, sum1, sum2, winner, done, busy);
endinterface

// File: rtl/score_acc.sv
// score_acc: one player's card clamp, score register and bust detect.
// DEAL_CTRL_SOFT_ACE_EN lets an ace count 11 until a later card would bust.
module score_acc import card_pkg::*; #(
    parameter int CARD_W = 5,
    parameter int SUM_W = 6,
    parameter int LIMIT = BUST_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add,
    input  logic [CARD_W-1:0] rnd,
    output logic [SUM_W-1:0]  sum,
    output logic              bust
);
    logic [SUM_W-1:0] card, nxt;
    assign card = rnd == '0 ? SUM_W'(CARD_MIN) : int'(rnd) > CARD_MAX ? SUM_W'(CARD_MAX) : SUM_W'(rnd);
`ifdef DEAL_CTRL_SOFT_ACE_EN
    logic soft, big, over;
    logic [SUM_W-1:0] raw;
    assign big = card == SUM_W'(CARD_MIN) && int'(sum) + 11 <= LIMIT;
    assign raw = sum + (big ? SUM_W'(11) : card);
    assign over = int'(raw) > LIMIT;
    // a held soft ace is demoted to 1 before the bust decision
    assign nxt = soft && over ? raw - SUM_W'(10) : raw;
    always_ff @(posedge clk or posedge rst)
        if (rst) soft <= 1'b0;
        else if (clr) soft <= 1'b0;
        else if (add) soft <= big | (soft & ~over);
`else
    assign nxt = sum + card;
`endif
    assign bust = int'(nxt) > LIMIT;
    always_ff @(posedge clk or posedge rst)
        if (rst) sum <= '0;
        else if (clr) sum <= '0;
        else if (add) sum <= nxt;
endmodule

// File: rtl/deal_ctrl.sv
// deal_ctrl: two-player card game turn sequencer (initial deal, hit/stand turns, winner).
// Build option DEAL_CTRL_SOFT_ACE_EN enables soft-ace scoring inside score_acc.
module deal_ctrl import card_pkg::*; #(
    parameter int CARD_W = 5,
    parameter int SUM_W = 6,
    parameter int LIMIT = BUST_LIMIT,
    parameter int INIT_CARDS = 2
) (
    input logic clk,
    input logic rst,
    deal_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(2 * INIT_CARDS + 1);
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0] win, win_nxt;
    logic clr, deal, whose, bust1, bust2;
    logic [SUM_W-1:0] sum1, sum2;
    // outputs decode from registered state only
    assign deal = state inside {INIT, P1_DRAW, P2_DRAW};
    assign whose = state inside {P2_WAIT, P2_DRAW} || (state == INIT && cnt[0]);
    score_acc #(.CARD_W(CARD_W), .SUM_W(SUM_W), .LIMIT(LIMIT)) u_p1 (
        .clk(clk), .rst(rst), .clr(clr), .add(deal & ~whose), .rnd(bus.rnd), .sum(sum1), .bust(bust1)
    );
    score_acc #(.CARD_W(CARD_W), .SUM_W(SUM_W), .LIMIT(LIMIT)) u_p2 (
        .clk(clk), .rst(rst), .clr(clr), .add(deal & whose), .rnd(bus.rnd), .sum(sum2), .bust(bust2)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            win <= WIN_NONE;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            win <= win_nxt;
        end
    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        win_nxt = win;
        clr = 1'b0;
        case (state)
            IDLE, RESULT: if (bus.start) begin
                state_nxt = INIT;
                cnt_nxt = '0;
                win_nxt = WIN_NONE;
                clr = 1'b1;
            end
            INIT: begin
                cnt_nxt = cnt + 1'b1;
                state_nxt = cnt == CNT_W'(2 * INIT_CARDS - 1) ? P1_WAIT : INIT;
            end
            P1_WAIT: state_nxt = bus.hit ? P1_DRAW : bus.stand ? P2_WAIT : P1_WAIT;
            P1_DRAW: begin
                state_nxt = bust1 ? RESULT : P1_WAIT;
                win_nxt = bust1 ? WIN_P2 : win;
            end
            P2_WAIT: begin
                state_nxt = bus.hit ? P2_DRAW : bus.stand ? RESULT : P2_WAIT;
                win_nxt = bus.hit || !bus.stand ? win : sum1 > sum2 ? WIN_P1 : sum1 < sum2 ? WIN_P2 : WIN_TIE;
            end
            P2_DRAW: begin
                state_nxt = bust2 ? RESULT : P2_WAIT;
                win_nxt = bust2 ? WIN_P1 : win;
            end
            default: state_nxt = IDLE;
        endcase
    end
    assign bus.deal = deal;
    assign bus.whose = whose;
    assign bus.sum1 = sum1;
    assign bus.sum2 = sum2;
    assign bus.winner = win;
    assign bus.done = state == RESULT;
    assign bus.busy = !(state inside {IDLE, RESULT});
endmodule

// File: tb/tb_deal_ctrl.sv
// tb_deal_ctrl: scoreboard bench for deal_ctrl; every dealt card is checked for select and resulting score
module tb_deal_ctrl;
    typedef struct { logic who; int sum; } exp_t;
    logic clk = 0;
    logic rst = 0;
    always #5 clk = ~clk;
    deal_ctrl_if #(.CARD_W(5), .SUM_W(6)) bus();
    deal_ctrl dut(.clk(clk), .rst(rst), .bus(bus.slave));
    exp_t q[$];
    exp_t cur;
    int checks = 0;
    int errors = 0;
    int m1, m2;
    bit sf1, sf2, pend;
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d @%0t", tag, act, exp, $time);
        end
    endtask
    task automatic mdl(inout int s, inout bit sf, input int r);
        int v;
        v = r == 0 ? 1 : r > 10 ? 10 : r;
`ifdef DEAL_CTRL_SOFT_ACE_EN
        if (v == 1 && s + 11 <= 21) begin
            s += 11;
            sf = 1;
        end else begin
            s += v;
            if (s > 21 && sf) begin
                s -= 10;
                sf = 0;
            end
        end
`else
        s += v;
`endif
    endtask
    task automatic push(input bit who, input int r);
        if (who) begin
            mdl(m2, sf2, r);
            q.push_back('{1'b1, m2});
        end else begin
            mdl(m1, sf1, r);
            q.push_back('{1'b0, m1});
        end
    endtask
    always @(negedge clk) begin
        if (pend) begin
            chk("sum", cur.who ? 32'(bus.sum2) : 32'(bus.sum1), cur.sum);
            pend = 0;
        end
        if (bus.deal) begin
            if (q.size() == 0) chk("deal_unexp", bus.deal, 0);
            else begin
                cur = q.pop_front();
                chk("whose", bus.whose, cur.who);
                pend = 1;
            end
        end
    end
    task automatic start_game(input int c0, input int c1, input int c2, input int c3);
        int c[4];
        c = '{c0, c1, c2, c3};
        m1 = 0; m2 = 0; sf1 = 0; sf2 = 0;
        @(posedge clk) #1 bus.start = 1;
        @(posedge clk) #1 bus.start = 0;
        for (int i = 0; i < 4; i++) begin
            bus.rnd = 5'(c[i]);
            push(i[0], c[i]);
            @(posedge clk) #1;
        end
    endtask
    task automatic do_hit(input bit who, input int r, input bit with_stand);
        bus.hit = 1;
        bus.stand = with_stand;
        bus.rnd = 5'(r);
        push(who, r);
        @(posedge clk) #1 bus.hit = 0;
        bus.stand = 0;
        @(posedge clk) #1;
    endtask
    task automatic do_stand();
        bus.stand = 1;
        @(posedge clk) #1 bus.stand = 0;
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_whose"}, bus.whose, 0);
        chk({tag, "_deal"}, bus.deal, 0);
        chk({tag, "_sum1"}, bus.sum1, 0);
        chk({tag, "_sum2"}, bus.sum2, 0);
        chk({tag, "_winner"}, bus.winner, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask
    function automatic logic [1:0] judge();
        return m1 > m2 ? 2'b01 : m1 < m2 ? 2'b10 : 2'b11;
    endfunction
    initial begin
        bus.start = 0; bus.hit = 0; bus.stand = 0; bus.rnd = 0;
        #1 rst = 1;
        #10 chk_idle("rst");
        @(posedge clk) #1 rst = 0;
        start_game(3, 4, 5, 6);
        bus.hit = 1;
        bus.rnd = 7;
        @(posedge clk) #2 rst = 1;
        bus.hit = 0;
        #1 chk_idle("rst_draw");
        @(posedge clk) #1 rst = 0;
        start_game(3, 4, 5, 6);
        chk("init_sum1", bus.sum1, 8);
        chk("init_sum2", bus.sum2, 10);
        chk("init_whose", bus.whose, 0);
        chk("init_busy", bus.busy, 1);
        bus.start = 1;
        @(posedge clk) #1 bus.start = 0;
        chk("busy_start_busy", bus.busy, 1);
        chk("busy_start_sum1", bus.sum1, 8);
        do_stand();
        chk("p2_whose", bus.whose, 1);
        do_stand();
        chk("cmp_winner", bus.winner, judge());
        chk("cmp_done", bus.done, 1);
        chk("cmp_busy", bus.busy, 0);
        start_game(10, 10, 10, 9);
        do_hit(0, 5, 0);
        chk("p1bust_sum1", bus.sum1, 25);
        chk("p1bust_winner", bus.winner, 2'b10);
        chk("p1bust_done", bus.done, 1);
        bus.hit = 1;
        bus.rnd = 7;
        repeat (3) @(posedge clk);
        #1 bus.hit = 0;
        chk("result_hold_sum1", bus.sum1, 25);
        chk("result_hold_done", bus.done, 1);
        start_game(10, 10, 10, 9);
        do_stand();
        do_hit(1, 0, 0);
        chk("tie_sum2", bus.sum2, 20);
        do_stand();
        chk("tie_winner", bus.winner, 2'b11);
        chk("tie_done", bus.done, 1);
        start_game(10, 10, 10, 9);
        do_stand();
        do_hit(1, 31, 1);
        chk("p2bust_sum2", bus.sum2, 29);
        chk("p2bust_winner", bus.winner, 2'b01);
        chk("p2bust_done", bus.done, 1);
`ifdef DEAL_CTRL_SOFT_ACE_EN
        start_game(1, 2, 5, 3);
        chk("soft_sum1", bus.sum1, 16);
        do_hit(0, 9, 0);
        chk("soft_hit_sum1", bus.sum1, 15);
        chk("soft_hit_done", bus.done, 0);
        chk("soft_hit_busy", bus.busy, 1);
`endif
        repeat (3) @(posedge clk);
        #1 chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
